imm_alu_ctrl_seq: RTL

Hardwired control sequencer for the Mini-SRC immediate-ALU instruction class (addi, andi, ori), plus halt. It drives the datapath control strobes for fetch (T0–T2) and execute (T3–T5) from a registered state machine, replacing hand-timed bench stimulus with synthesizable control. Memory read latency is parametrised, and the block adds run/stop, halt and illegal-opcode trapping.

---
 rtl/imm_alu_ctrl_seq_if.sv | 41 ++++
 rtl/imm_alu_ctrl_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imm_alu_ctrl_seq_if.sv
// Control bundle between the immediate-ALU sequencer and the Mini-SRC datapath.
// Latency: n/a (wires only).
// Backpressure: none; Run is a level enable, strobes are unconditional.
//
// master: sequencer side, drives the strobes, Step/Halted/Illegal and OP, and
//         observes Run and IR_op.
// slave : datapath/bench side, the mirror image.
interface imm_alu_ctrl_seq_if #(
  parameter int unsigned OP_W = 5
);
  logic            Run;
  logic [4:0]      IR_op;
  // fetch strobes
  logic            PCout, MARin, IncPC;
  logic            PCin, Read, MDRin;
  logic            MDRout, IRin;
  // execute strobes
  logic            Grb, Rout, Yin;
  logic            Cout, ZHighin, ZLowin;
  logic [OP_W-1:0] OP;
  logic            ZLowout, Gra, Rin;
  logic            ZHighout;
  // status
  logic [3:0]      Step;
  logic            Halted;
  logic            Illegal;

  modport master (
    input  Run, IR_op,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Grb, Rout, Yin, Cout, ZHighin, ZLowin, OP,
           ZLowout, Gra, Rin, ZHighout, Step, Halted, Illegal
  );

  modport slave (
    output Run, IR_op,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Grb, Rout, Yin, Cout, ZHighin, ZLowin, OP,
           ZLowout, Gra, Rin, ZHighout, Step, Halted, Illegal
  );
endinterface

// File: rtl/imm_alu_ctrl_seq.sv
// Hardwired fetch/execute sequencer for Mini-SRC addi/andi/ori plus halt.
// Latency: one state per clock, T1 held MEM_WAIT+1 clocks; 6+MEM_WAIT per instruction.
// Backpressure: none; Run is sampled only in IDLE and at the end of T5.
//
// Ports:
//   Clock  - single rising-edge clock
//   Clear  - synchronous active-low reset, overrides every state
//   bus    - imm_alu_ctrl_seq_if.master: Run/IR_op in; T0..T5 strobes, OP,
//            ZHighout (tied 0), Step, Halted, Illegal out
module imm_alu_ctrl_seq #(
  parameter int unsigned     MEM_WAIT = 0,
  parameter int unsigned     OP_W     = 5,
  parameter logic [OP_W-1:0] ALU_ADD  = 5'b00011,
  parameter logic [OP_W-1:0] ALU_AND  = 5'b00000,
  parameter logic [OP_W-1:0] ALU_OR   = 5'b00001
) (
  input  logic                Clock,
  input  logic                Clear,
  imm_alu_ctrl_seq_if.master  bus
);

  // Opcodes in IR[31:27]
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  // Encoding doubles as the externally visible Step code.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_HALT  = 4'd14,
    S_FAULT = 4'd15
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wait;
  logic [3:0]      w_wait_nxt;
  logic [OP_W-1:0] r_alu;
  logic [OP_W-1:0] w_alu_nxt;

  logic            w_legal;
  logic            w_halt;
  logic [OP_W-1:0] w_alu_code;
  logic            w_t1_last;

  // ---------------------------------------------------------------------
  // Opcode decode. Only consumed in T3, where IR_op is guaranteed stable.
  // ---------------------------------------------------------------------
  always_comb begin
    w_legal    = 1'b0;
    w_halt     = 1'b0;
    w_alu_code = '0;
    case (bus.IR_op)
      OPC_ADDI: begin w_legal = 1'b1; w_alu_code = ALU_ADD; end
      OPC_ANDI: begin w_legal = 1'b1; w_alu_code = ALU_AND; end
      OPC_ORI:  begin w_legal = 1'b1; w_alu_code = ALU_OR;  end
      OPC_HALT: w_halt = 1'b1;
      default:  ;
    endcase
  end

  // Wait counter is loaded with MEM_WAIT when T1 is entered, so the final
  // T1 cycle is simply the one in which it has reached zero.
  assign w_t1_last = (r_wait == 4'd0);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_alu_nxt   = r_alu;
    case (r_state)
      S_IDLE: begin
        if (bus.Run) w_state_nxt = S_T0;
      end
      S_T0: begin
        w_state_nxt = S_T1;
        w_wait_nxt  = WAIT_INIT;
      end
      S_T1: begin
        if (w_t1_last) begin
          w_state_nxt = S_T2;
        end else begin
          w_wait_nxt = r_wait - 4'd1;
        end
      end
      S_T2: w_state_nxt = S_T3;
      S_T3: begin
        if (w_legal) begin
          w_state_nxt = S_T4;
          w_alu_nxt   = w_alu_code;
        end else if (w_halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      S_T4: w_state_nxt = S_T5;
      S_T5: w_state_nxt = bus.Run ? S_T0 : S_IDLE;
      // HALT and FAULT are left only through Clear.
      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_alu   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_alu   <= w_alu_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode from the state register.
  // The T3 group is additionally qualified by the decoded opcode so that a
  // halt or illegal instruction never touches the register file.
  // ---------------------------------------------------------------------
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Grb      = 1'b0;
    bus.Rout     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Cout     = 1'b0;
    bus.ZHighin  = 1'b0;
    bus.ZLowin   = 1'b0;
    bus.OP       = '0;
    bus.ZLowout  = 1'b0;
    bus.Gra      = 1'b0;
    bus.Rin      = 1'b0;
    bus.ZHighout = 1'b0;
    bus.Halted   = 1'b0;
    bus.Illegal  = 1'b0;
    bus.Step     = r_state;
    case (r_state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
      end
      S_T1: begin
        bus.Read  = 1'b1;
        // PC and MDR capture only once the memory data is valid.
        bus.PCin  = w_t1_last;
        bus.MDRin = w_t1_last;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.Grb  = w_legal;
        bus.Rout = w_legal;
        bus.Yin  = w_legal;
      end
      S_T4: begin
        bus.Cout    = 1'b1;
        bus.ZHighin = 1'b1;
        bus.ZLowin  = 1'b1;
        bus.OP      = r_alu;
      end
      S_T5: begin
        bus.ZLowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
      end
      S_HALT:  bus.Halted  = 1'b1;
      S_FAULT: bus.Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
